// File: rtl/axi_rd_arbiter.sv
`default_nettype none
// ============================================================================
// axi_rd_arbiter : N-client AXI4 read arbiter, one AR in flight, R beats routed
// by ID. Macro AXI_RD_ARB_FIXED_PRIO_EN selects fixed priority (else RR).
// Revision: 1.0
// ============================================================================
module axi_rd_arbiter #(
  parameter int N_PORTS = 2,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_PORTS-1:0]        req_valid,
  output logic [N_PORTS-1:0]        req_ready,
  input  logic [N_PORTS*ADDR_W-1:0] req_addr,
  input  logic [N_PORTS*8-1:0]      req_len,
  output logic [N_PORTS-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_data,
  output logic                      rsp_last,
  output logic                      rsp_err,
  output logic [N_PORTS-1:0]        busy,
  output logic                      stray_rid,
  output logic [3:0]                arid,
  output logic [ADDR_W-1:0]         araddr,
  output logic [7:0]                arlen,
  output logic [2:0]                arsize,
  output logic [1:0]                arburst,
  output logic                      arvalid,
  input  logic                      arready,
  input  logic [3:0]                rid,
  input  logic [DATA_W-1:0]         rdata,
  input  logic [1:0]                rresp,
  input  logic                      rlast,
  input  logic                      rvalid,
  output logic                      rready
);

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    AR_WAIT = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [3:0]         arid_q, arid_d;
  logic [ADDR_W-1:0]  araddr_q, araddr_d;
  logic [7:0]         arlen_q, arlen_d;
  logic [N_PORTS-1:0] busy_q, busy_d;
  logic               stray_q, stray_d;

  logic [N_PORTS-1:0] elig;
  logic [N_PORTS-1:0] gnt;
  logic               gnt_any;
  logic [3:0]         gnt_idx;
  logic [ADDR_W-1:0]  gnt_addr;
  logic [7:0]         gnt_len;
  logic [15:0]        busy_ext;
  logic [15:0]        rid_dec;
  logic               r_hit;
  logic [N_PORTS-1:0] r_sel;

  assign elig = req_valid & ~busy_q;

`ifdef AXI_RD_ARB_FIXED_PRIO_EN
  // Scan downward so the lowest eligible index is the last one written.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = 4'd0;
    for (int i = N_PORTS - 1; i >= 0; i--) begin
      if (elig[i]) begin
        gnt_any = 1'b1;
        gnt_idx = 4'(i);
      end
    end
  end
`else
  localparam int PTR_W = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;

  logic [PTR_W-1:0] rr_q, rr_d;

  // Scan offsets downward so the eligible client nearest the pointer wins.
  always_comb begin
    int cand;
    cand    = 0;
    gnt_any = 1'b0;
    gnt_idx = 4'd0;
    for (int off = N_PORTS - 1; off >= 0; off--) begin
      cand = int'(rr_q) + off;
      if (cand >= N_PORTS) begin
        cand = cand - N_PORTS;
      end
      if (elig[cand[PTR_W-1:0]]) begin
        gnt_any = 1'b1;
        gnt_idx = 4'(cand);
      end
    end
  end

  always_comb begin
    rr_d = rr_q;
    if ((state_q == IDLE) && gnt_any) begin
      rr_d = (gnt_idx == 4'(N_PORTS - 1)) ? '0 : PTR_W'(gnt_idx + 4'd1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_q <= '0;
    end else begin
      rr_q <= rr_d;
    end
  end
`endif

  always_comb begin
    gnt = '0;
    for (int i = 0; i < N_PORTS; i++) begin
      gnt[i] = gnt_any && (gnt_idx == 4'(i));
    end
  end

  always_comb begin
    gnt_addr = '0;
    gnt_len  = '0;
    for (int i = 0; i < N_PORTS; i++) begin
      if (gnt[i]) begin
        gnt_addr = req_addr[i*ADDR_W +: ADDR_W];
        gnt_len  = req_len[i*8 +: 8];
      end
    end
  end

  // Zero-extending busy to 16 bits makes any rid >= N_PORTS miss naturally.
  assign busy_ext = 16'(busy_q);
  assign rid_dec  = 16'd1 << rid;
  assign r_hit    = rvalid & busy_ext[rid];
  assign r_sel    = r_hit ? rid_dec[N_PORTS-1:0] : '0;

  always_comb begin
    state_d  = state_q;
    arid_d   = arid_q;
    araddr_d = araddr_q;
    arlen_d  = arlen_q;
    busy_d   = busy_q & ~(rlast ? r_sel : '0);
    stray_d  = rvalid & ~r_hit;
    case (state_q)
      IDLE: begin
        if (gnt_any) begin
          state_d  = AR_WAIT;
          arid_d   = gnt_idx;
          araddr_d = gnt_addr;
          arlen_d  = gnt_len;
          busy_d   = busy_d | gnt;
        end
      end
      AR_WAIT: begin
        if (arready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      arid_q   <= 4'd0;
      araddr_q <= '0;
      arlen_q  <= 8'd0;
      busy_q   <= '0;
      stray_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      arid_q   <= arid_d;
      araddr_q <= araddr_d;
      arlen_q  <= arlen_d;
      busy_q   <= busy_d;
      stray_q  <= stray_d;
    end
  end

  assign req_ready = ((state_q == IDLE) && !rst) ? gnt : '0;
  assign rsp_valid = rst ? '0 : r_sel;
  assign rsp_data  = rdata;
  assign rsp_last  = rlast;
  assign rsp_err   = |rresp;
  assign busy      = busy_q;
  assign stray_rid = stray_q;
  assign arid      = arid_q;
  assign araddr    = araddr_q;
  assign arlen     = arlen_q;
  assign arvalid   = (state_q == AR_WAIT);
  assign arsize    = 3'b010;
  assign arburst   = 2'b01;
  assign rready    = 1'b1;

endmodule
`default_nettype wire

// File: tb/tb_axi_rd_arbiter.sv
`default_nettype none
// Testbench for axi_rd_arbiter: directed scenarios plus a randomized run
// against a transaction-level reference model.
module tb_axi_rd_arbiter;
  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;
`ifdef AXI_RD_ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  req_valid, req_ready, rsp_valid, busy;
  logic [N*AW-1:0] req_addr;
  logic [N*8-1:0]  req_len;
  logic [DW-1:0] rsp_data, rdata;
  logic          rsp_last, rsp_err, stray_rid;
  logic [3:0]    arid, rid;
  logic [AW-1:0] araddr;
  logic [7:0]    arlen;
  logic [2:0]    arsize;
  logic [1:0]    arburst, rresp;
  logic          arvalid, arready, rlast, rvalid, rready;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  axi_rd_arbiter #(.N_PORTS(N), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_len(req_len),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_last(rsp_last),
    .rsp_err(rsp_err), .busy(busy), .stray_rid(stray_rid),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
    .arburst(arburst), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
    .rvalid(rvalid), .rready(rready)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req_valid = '0; req_addr = '0; req_len = '0; arready = 1'b0;
    rid = 4'd0; rdata = '0; rresp = 2'b00; rlast = 1'b0; rvalid = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Drives one request to completion of its AR handshake; ok=0 on timeout.
  task automatic issue(input int idx, input logic [AW-1:0] a, input logic [7:0] l,
                       output bit ok);
    req_addr[idx*AW +: AW] = a;
    req_len[idx*8 +: 8]    = l;
    req_valid[idx]         = 1'b1;
    arready                = 1'b1;
    ok = 1'b0;
    for (int c = 0; c < 20 && !ok; c++) begin
      tick();
      if (busy[idx] && !arvalid) ok = 1'b1;
    end
    req_valid[idx] = 1'b0;
    arready        = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    req_valid = '1;
    rvalid = 1'b1; rid = 4'd0; rlast = 1'b1;
    tick();
    @(negedge clk);
    checks++;
    if ({arvalid, arid, araddr, arlen} !== {1'b0, 4'd0, 32'd0, 8'd0}) begin
      errors++;
      $display("FAIL reset_ar: got arvalid=%b arid=%0d araddr=%h arlen=%0d want all 0",
               arvalid, arid, araddr, arlen);
    end
    checks++;
    if ({busy, req_ready, rsp_valid, stray_rid} !== '0) begin
      errors++;
      $display("FAIL reset_status: got busy=%b req_ready=%b rsp_valid=%b stray=%b want 0",
               busy, req_ready, rsp_valid, stray_rid);
    end
    checks++;
    if ({rready, arsize, arburst} !== {1'b1, 3'b010, 2'b01}) begin
      errors++;
      $display("FAIL reset_consts: got rready=%b arsize=%b arburst=%b want 1/010/01",
               rready, arsize, arburst);
    end
    tick();
    idle_inputs();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_round_robin();
    logic [N-1:0] got, want;
    bit found;
    int idx;
    do_reset();
    req_valid = '1;
    arready = 1'b1;
    for (int g = 0; g < 5; g++) begin
      found = 1'b0;
      got = '0;
      for (int c = 0; c < 10 && !found; c++) begin
        @(negedge clk);
        if (req_ready != '0) begin
          found = 1'b1;
          got = req_ready;
        end else begin
          tick();
        end
      end
      want = FIXED ? N'(1) : N'(1) << (g % N);
      checks++;
      if (!found || got !== want) begin
        errors++;
        $display("FAIL rr_grant%0d: got req_ready=%b want %b (found=%0d)", g, got, want, found);
        break;
      end
      idx = 0;
      for (int i = 0; i < N; i++) if (got[i]) idx = i;
      tick();
      rvalid = 1'b1; rid = 4'(idx); rlast = 1'b1;
      tick();
      rvalid = 1'b0; rlast = 1'b0;
    end
    idle_inputs();
  endtask

  task automatic test_back_pressure();
    logic [AW-1:0] a;
    logic [7:0] l;
    int pulses;
    do_reset();
    a = $urandom;
    l = 8'($urandom_range(0, 255));
    req_addr[2*AW +: AW] = a;
    req_len[16 +: 8] = l;
    req_valid = 4'b0100;
    arready = 1'b0;
    pulses = 0;
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b0100) begin
      errors++;
      $display("FAIL bp_grant: got req_ready=%b want 0100", req_ready);
    end
    if (req_ready != '0) pulses++;
    tick();
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++;
      if ({arvalid, arid, araddr, arlen} !== {1'b1, 4'd2, a, l}) begin
        errors++;
        $display("FAIL bp_stable%0d: got v=%b id=%0d addr=%h len=%0d want 1/2/%h/%0d",
                 c, arvalid, arid, araddr, arlen, a, l);
      end
      if (req_ready != '0) pulses++;
      tick();
    end
    arready = 1'b1;
    @(negedge clk);
    if (req_ready != '0) pulses++;
    tick();
    arready = 1'b0;
    @(negedge clk);
    if (req_ready != '0) pulses++;
    checks++;
    if (arvalid !== 1'b0) begin
      errors++;
      $display("FAIL bp_drop: got arvalid=%b want 0", arvalid);
    end
    checks++;
    if (pulses != 1) begin
      errors++;
      $display("FAIL bp_pulses: got %0d req_ready pulses want 1", pulses);
    end
    tick();
    idle_inputs();
  endtask

  task automatic test_out_of_order();
    bit ok0, ok1;
    logic [DW-1:0] d;
    do_reset();
    issue(0, $urandom, 8'd1, ok0);
    issue(1, $urandom, 8'd0, ok1);
    checks++;
    if (!ok0 || !ok1 || busy !== 4'b0011) begin
      errors++;
      $display("FAIL ooo_setup: got ok0=%0d ok1=%0d busy=%b want 1/1/0011", ok0, ok1, busy);
    end
    d = $urandom;
    rvalid = 1'b1; rid = 4'd1; rlast = 1'b1; rdata = d;
    @(negedge clk);
    checks++;
    if ({rsp_valid, rsp_data, rsp_last} !== {4'b0010, d, 1'b1}) begin
      errors++;
      $display("FAIL ooo_beat1: got v=%b data=%h last=%b want 0010/%h/1",
               rsp_valid, rsp_data, rsp_last, d);
    end
    tick();
    checks++;
    if (busy !== 4'b0001) begin
      errors++;
      $display("FAIL ooo_busy1: got busy=%b want 0001", busy);
    end
    rid = 4'd0; rlast = 1'b0;
    @(negedge clk);
    checks++;
    if (rsp_valid !== 4'b0001) begin
      errors++;
      $display("FAIL ooo_beat2: got rsp_valid=%b want 0001", rsp_valid);
    end
    tick();
    rlast = 1'b1;
    @(negedge clk);
    checks++;
    if ({rsp_valid, rsp_last} !== {4'b0001, 1'b1}) begin
      errors++;
      $display("FAIL ooo_beat3: got rsp_valid=%b last=%b want 0001/1", rsp_valid, rsp_last);
    end
    tick();
    rvalid = 1'b0; rlast = 1'b0;
    checks++;
    if (busy !== 4'b0000) begin
      errors++;
      $display("FAIL ooo_busy0: got busy=%b want 0000", busy);
    end
    idle_inputs();
  endtask

  task automatic test_err_stray();
    bit ok;
    do_reset();
    issue(1, $urandom, 8'd0, ok);
    rvalid = 1'b1; rid = 4'd5; rlast = 1'b1; rresp = 2'b00;
    @(negedge clk);
    checks++;
    if (!ok || rsp_valid !== 4'b0000) begin
      errors++;
      $display("FAIL stray_rid5_route: got rsp_valid=%b ok=%0d want 0000/1", rsp_valid, ok);
    end
    tick();
    rid = 4'd2;
    checks++;
    if (stray_rid !== 1'b1) begin
      errors++;
      $display("FAIL stray_rid5_pulse: got stray_rid=%b want 1", stray_rid);
    end
    @(negedge clk);
    checks++;
    if (rsp_valid !== 4'b0000) begin
      errors++;
      $display("FAIL stray_idle_client: got rsp_valid=%b want 0000", rsp_valid);
    end
    tick();
    rid = 4'd1; rresp = 2'b10;
    checks++;
    if (stray_rid !== 1'b1) begin
      errors++;
      $display("FAIL stray_idle_pulse: got stray_rid=%b want 1", stray_rid);
    end
    @(negedge clk);
    checks++;
    if ({rsp_valid, rsp_err} !== {4'b0010, 1'b1}) begin
      errors++;
      $display("FAIL err_beat: got rsp_valid=%b rsp_err=%b want 0010/1", rsp_valid, rsp_err);
    end
    tick();
    rvalid = 1'b0;
    checks++;
    if ({stray_rid, busy} !== {1'b0, 4'b0000}) begin
      errors++;
      $display("FAIL err_after: got stray=%b busy=%b want 0/0000", stray_rid, busy);
    end
    idle_inputs();
  endtask

  task automatic test_simultaneous();
    bit ok;
    do_reset();
    issue(0, $urandom, 8'd0, ok);
    req_addr[AW +: AW] = $urandom;
    req_valid = 4'b0010;
    arready = 1'b0;
    @(negedge clk);
    checks++;
    if (!ok || req_ready !== 4'b0010) begin
      errors++;
      $display("FAIL sim_grant: got req_ready=%b ok=%0d want 0010/1", req_ready, ok);
    end
    tick();
    req_valid = '0;
    arready = 1'b1;
    rvalid = 1'b1; rid = 4'd0; rlast = 1'b1;
    @(negedge clk);
    checks++;
    if ({arvalid, arid, rsp_valid} !== {1'b1, 4'd1, 4'b0001}) begin
      errors++;
      $display("FAIL sim_both: got arvalid=%b arid=%0d rsp_valid=%b want 1/1/0001",
               arvalid, arid, rsp_valid);
    end
    tick();
    idle_inputs();
    checks++;
    if ({busy, arvalid} !== {4'b0010, 1'b0}) begin
      errors++;
      $display("FAIL sim_busy: got busy=%b arvalid=%b want 0010/0", busy, arvalid);
    end
  endtask

  task automatic test_reset_mid_burst();
    bit ok;
    int pulses;
    do_reset();
    issue(0, $urandom, 8'd3, ok);
    req_valid = 4'b0010;
    rvalid = 1'b1; rid = 4'd0; rlast = 1'b0;
    tick();
    tick();
    rvalid = 1'b0;
    checks++;
    if (!ok || {busy, arvalid} !== {4'b0011, 1'b1}) begin
      errors++;
      $display("FAIL mid_setup: got busy=%b arvalid=%b ok=%0d want 0011/1/1", busy, arvalid, ok);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({busy, arvalid} !== {4'b0000, 1'b0}) begin
      errors++;
      $display("FAIL mid_reset: got busy=%b arvalid=%b want 0000/0", busy, arvalid);
    end
    req_valid = '0;
    tick();
    rst = 1'b0;
    pulses = 0;
    for (int b = 0; b < 2; b++) begin
      rvalid = 1'b1; rid = 4'd0; rlast = (b == 1);
      @(negedge clk);
      checks++;
      if (rsp_valid !== 4'b0000) begin
        errors++;
        $display("FAIL mid_late%0d: got rsp_valid=%b want 0000", b, rsp_valid);
      end
      tick();
      if (stray_rid) pulses++;
    end
    rvalid = 1'b0;
    tick();
    checks++;
    if (pulses != 2 || stray_rid !== 1'b0) begin
      errors++;
      $display("FAIL mid_stray: got %0d pulses, stray now %b want 2/0", pulses, stray_rid);
    end
    idle_inputs();
  endtask

  // Reference model works on transactions: one pending AR, a busy set, a pointer.
  task automatic test_random();
    logic [N-1:0] m_busy, elig, exp_rr, exp_rv;
    int m_ptr, w, r, c;
    bit m_arv, m_stray, hit;
    logic [3:0] m_arid;
    logic [AW-1:0] m_addr;
    logic [7:0] m_len;
    do_reset();
    m_busy = '0; m_ptr = 0; m_arv = 1'b0; m_stray = 1'b0;
    m_arid = '0; m_addr = '0; m_len = '0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      req_valid = N'($urandom);
      for (int i = 0; i < N; i++) begin
        req_addr[i*AW +: AW] = $urandom;
        req_len[i*8 +: 8] = 8'($urandom);
      end
      arready = 1'($urandom_range(0, 1));
      rvalid  = ($urandom_range(0, 9) < 6);
      rid     = ($urandom_range(0, 9) < 7) ? 4'($urandom_range(0, N - 1)) : 4'($urandom_range(N, 15));
      rlast   = 1'($urandom_range(0, 1));
      rresp   = 2'($urandom);
      rdata   = $urandom;

      elig = req_valid & ~m_busy;
      w = -1;
      if (!m_arv) begin
        for (int k = 0; k < N; k++) begin
          c = FIXED ? k : (m_ptr + k) % N;
          if (w < 0 && elig[c]) w = c;
        end
      end
      exp_rr = '0;
      if (w >= 0) exp_rr[w] = 1'b1;
      r = int'(rid);
      hit = 1'b0;
      if (rvalid && r < N) hit = m_busy[r];
      exp_rv = '0;
      if (hit) exp_rv[r] = 1'b1;

      @(negedge clk);
      checks++;
      if (req_ready !== exp_rr || rsp_valid !== exp_rv) begin
        errors++;
        $display("FAIL rnd_comb c%0d: got ready=%b rsp_valid=%b want %b/%b",
                 cyc, req_ready, rsp_valid, exp_rr, exp_rv);
      end
      if (hit) begin
        checks++;
        if ({rsp_data, rsp_last, rsp_err} !== {rdata, rlast, (rresp != 2'b00)}) begin
          errors++;
          $display("FAIL rnd_beat c%0d: got data=%h last=%b err=%b want %h/%b/%b",
                   cyc, rsp_data, rsp_last, rsp_err, rdata, rlast, (rresp != 2'b00));
        end
      end
      checks++;
      if (busy !== m_busy || stray_rid !== m_stray || arvalid !== m_arv) begin
        errors++;
        $display("FAIL rnd_state c%0d: got busy=%b stray=%b arvalid=%b want %b/%b/%b",
                 cyc, busy, stray_rid, arvalid, m_busy, m_stray, m_arv);
      end
      if (m_arv) begin
        checks++;
        if ({arid, araddr, arlen} !== {m_arid, m_addr, m_len}) begin
          errors++;
          $display("FAIL rnd_ar c%0d: got id=%0d addr=%h len=%0d want %0d/%h/%0d",
                   cyc, arid, araddr, arlen, m_arid, m_addr, m_len);
        end
      end

      m_stray = rvalid && !hit;
      if (hit && rlast) m_busy[r] = 1'b0;
      if (m_arv) begin
        if (arready) m_arv = 1'b0;
      end else if (w >= 0) begin
        m_arv  = 1'b1;
        m_arid = 4'(w);
        m_addr = req_addr[w*AW +: AW];
        m_len  = req_len[w*8 +: 8];
        m_busy[w] = 1'b1;
        m_ptr = (w + 1) % N;
      end
      tick();
    end
    idle_inputs();
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_round_robin();
    test_back_pressure();
    test_out_of_order();
    test_err_stray();
    test_simultaneous();
    test_reset_mid_burst();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
